// File: rtl/gso_pkg.sv
// rtl/gso_pkg.sv - shared angle constants, flat-index helper and FSM encoding
package gso_pkg;

    // Angle LSB is pi / 2^(ANGLE_WIDTH-1); for 16-bit angles 16'h4000 is +pi/2.
    localparam int          ANGLE_FRAC_LOG2 = 15;
    localparam logic [15:0] ANGLE_HALF_PI   = 16'h4000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STORE = 3'd3,
        ST_FIN   = 3'd4
    } fsm_state_t;

    // Entry (j,i) of a k x k angle matrix in the flattened bus.
    function automatic int flat_idx(input int j, input int i, input int k);
        return j * k + i;
    endfunction

endpackage

// File: rtl/theta_row_buf.sv
// rtl/theta_row_buf.sv - K x K angle register array with single-entry write and clear
import gso_pkg::*;

module theta_row_buf #(
    parameter int ANGLE_WIDTH = 16,
    parameter int K_VECTORS   = 6,
    parameter int ROW_W       = 3,
    parameter int COL_W       = 3
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clear,
    input  logic                                     wr_en,
    input  logic [ROW_W-1:0]                         wr_row,
    input  logic [COL_W-1:0]                         wr_col,
    input  logic [ANGLE_WIDTH-1:0]                   wr_data,
    output logic [ANGLE_WIDTH*K_VECTORS*K_VECTORS-1:0] thetas_flat
);

    logic [ANGLE_WIDTH*K_VECTORS*K_VECTORS-1:0] flat_q;

    assign thetas_flat = flat_q;

    // Clear wipes every row; otherwise a write touches exactly one entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flat_q <= '0;
        end else if (clear) begin
            flat_q <= '0;
        end else if (wr_en) begin
            flat_q[flat_idx(int'(wr_row), int'(wr_col), K_VECTORS)*ANGLE_WIDTH +: ANGLE_WIDTH] <= wr_data;
        end
    end

endmodule

// File: rtl/theta_extract.sv
// rtl/theta_extract.sv - converts a weight vector into hyperspherical angles via external CORDIC
import gso_pkg::*;

module theta_extract #(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16,
    parameter int N_DIM       = 7,
    parameter int K_VECTORS   = N_DIM - 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic                                       clear,
    input  logic [2:0]                                 j_in,
    input  logic [DATA_WIDTH*N_DIM-1:0]                w_in_flat,
    output logic                                       cordic_vec_en,
    output logic [DATA_WIDTH-1:0]                      cordic_vec_xin,
    output logic [DATA_WIDTH-1:0]                      cordic_vec_yin,
    output logic                                       cordic_vec_angle_calc_en,
    input  logic                                       cordic_vec_opvld,
    input  logic [DATA_WIDTH-1:0]                      cordic_vec_xout,
    input  logic [ANGLE_WIDTH-1:0]                     vec_angle_out,
    output logic [ANGLE_WIDTH*K_VECTORS*K_VECTORS-1:0] thetas_out_flat,
    output logic [DATA_WIDTH-1:0]                      norm_out,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       err
);

    localparam int            IW       = (N_DIM > 2) ? $clog2(N_DIM) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DIM - 1);

    fsm_state_t state_q, state_d;

    logic accept, reject, do_issue, do_skip, do_latch, do_store, do_fin;
    logic row_clear;

    logic [DATA_WIDTH-1:0]  w_q [N_DIM];
    logic [DATA_WIDTH-1:0]  acc_q;
    logic [DATA_WIDTH-1:0]  mag_q;
    logic [DATA_WIDTH-1:0]  cur_w;
    logic [ANGLE_WIDTH-1:0] theta_q;
    logic [2:0]             j_q;
    logic [IW-1:0]          idx_q;

    assign cur_w     = w_q[idx_q];
    assign row_clear = clear && (state_q == ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and single-cycle datapath strobes.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        reject   = 1'b0;
        do_issue = 1'b0;
        do_skip  = 1'b0;
        do_latch = 1'b0;
        do_store = 1'b0;
        do_fin   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (32'(j_in) < K_VECTORS) begin
                        accept  = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // A zero pair has no defined angle; bypass the CORDIC and store 0.
                if ((acc_q == '0) && (cur_w == '0)) begin
                    do_skip = 1'b1;
                    state_d = ST_STORE;
                end else begin
                    do_issue = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cordic_vec_opvld) begin
                    do_latch = 1'b1;
                    state_d  = ST_STORE;
                end
            end
            ST_STORE: begin
                do_store = 1'b1;
                state_d  = (idx_q == LAST_IDX) ? ST_FIN : ST_ISSUE;
            end
            ST_FIN: begin
                do_fin  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, accumulator chain, CORDIC issue and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIM; i++) begin
                w_q[i] <= '0;
            end
            acc_q                    <= '0;
            mag_q                    <= '0;
            theta_q                  <= '0;
            j_q                      <= '0;
            idx_q                    <= '0;
            cordic_vec_en            <= 1'b0;
            cordic_vec_angle_calc_en <= 1'b0;
            cordic_vec_xin           <= '0;
            cordic_vec_yin           <= '0;
            norm_out                 <= '0;
            busy                     <= 1'b0;
            done                     <= 1'b0;
            err                      <= 1'b0;
        end else begin
            cordic_vec_en            <= do_issue;
            cordic_vec_angle_calc_en <= do_issue;
            done                     <= do_fin;
            err                      <= reject;
            // Stays high through the done cycle, which is already back in IDLE.
            busy                     <= (state_d != ST_IDLE) || do_fin;

            if (accept) begin
                for (int i = 0; i < N_DIM; i++) begin
                    w_q[i] <= w_in_flat[i*DATA_WIDTH +: DATA_WIDTH];
                end
                j_q   <= j_in;
                acc_q <= w_in_flat[DATA_WIDTH-1:0];
                idx_q <= IW'(1);
            end
            if (do_issue) begin
                cordic_vec_xin <= acc_q;
                cordic_vec_yin <= cur_w;
            end
            if (do_skip) begin
                theta_q <= '0;
                mag_q   <= '0;
            end
            if (do_latch) begin
                theta_q <= vec_angle_out;
                mag_q   <= cordic_vec_xout;
            end
            if (do_store) begin
                acc_q <= mag_q;
                if (idx_q != LAST_IDX) begin
                    idx_q <= idx_q + IW'(1);
                end
            end
            if (do_fin) begin
                norm_out <= acc_q;
            end
        end
    end

    theta_row_buf #(
        .ANGLE_WIDTH (ANGLE_WIDTH),
        .K_VECTORS   (K_VECTORS),
        .ROW_W       (3),
        .COL_W       (IW)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (row_clear),
        .wr_en       (do_store),
        .wr_row      (j_q),
        .wr_col      (idx_q - IW'(1)),
        .wr_data     (theta_q),
        .thetas_flat (thetas_out_flat)
    );

endmodule

// File: tb/tb_theta_extract.sv
// tb/tb_theta_extract.sv - self-checking bench for theta_extract with a behavioural CORDIC
module tb_theta_extract;

    localparam int  DW  = 16;
    localparam int  AW  = 16;
    localparam int  N   = 7;
    localparam int  K   = 6;
    localparam int  LAT = 3;
    localparam int  FW  = AW * K * K;
    localparam real PI  = 3.14159265358979323846;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            clear = 1'b0;
    logic [2:0]      j_in = 3'd0;
    logic [DW*N-1:0] w_in_flat = '0;
    logic            cordic_vec_en;
    logic [DW-1:0]   cordic_vec_xin;
    logic [DW-1:0]   cordic_vec_yin;
    logic            cordic_vec_angle_calc_en;
    logic            cordic_vec_opvld = 1'b0;
    logic [DW-1:0]   cordic_vec_xout = '0;
    logic [AW-1:0]   vec_angle_out = '0;
    logic [FW-1:0]   thetas_out_flat;
    logic [DW-1:0]   norm_out;
    logic            busy;
    logic            done;
    logic            err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    logic [AW-1:0] exp_buf [K][K];
    int            exp_norm = 0;
    int            exp_pulses = 0;
    logic [31:0]   op_q [$];
    int            wv [N];
    int            en_cnt = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;

    // Behavioural CORDIC state
    int            pend = 0;
    logic [AW-1:0] c_ang;
    logic [DW-1:0] c_mag;
    logic [31:0]   exp_op;

    theta_extract dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .start                    (start),
        .clear                    (clear),
        .j_in                     (j_in),
        .w_in_flat                (w_in_flat),
        .cordic_vec_en            (cordic_vec_en),
        .cordic_vec_xin           (cordic_vec_xin),
        .cordic_vec_yin           (cordic_vec_yin),
        .cordic_vec_angle_calc_en (cordic_vec_angle_calc_en),
        .cordic_vec_opvld         (cordic_vec_opvld),
        .cordic_vec_xout          (cordic_vec_xout),
        .vec_angle_out            (vec_angle_out),
        .thetas_out_flat          (thetas_out_flat),
        .norm_out                 (norm_out),
        .busy                     (busy),
        .done                     (done),
        .err                      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_near(input string name, input int act, input int expv, input int tol);
        n_checks++;
        if ((act > expv + tol) || (act < expv - tol)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, expv, tol);
        end
    endtask

    task automatic chk_flat(input string name, input logic [FW-1:0] act, input logic [FW-1:0] expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic void cordic_fn(input int x, input int y, output logic [AW-1:0] ang, output logic [DW-1:0] mag);
        real a;
        real r;
        int  ai;
        int  mi;
        r  = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        a  = $atan2(real'(y), real'(x));
        ai = (a >= 0.0) ? $rtoi(a * 32768.0 / PI + 0.5) : $rtoi(a * 32768.0 / PI - 0.5);
        mi = $rtoi(r + 0.5);
        ang = ai[AW-1:0];
        mag = mi[DW-1:0];
    endfunction

    function automatic logic [FW-1:0] exp_flat();
        logic [FW-1:0] f;
        f = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                f[(r*K+c)*AW +: AW] = exp_buf[r][c];
        return f;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                exp_buf[r][c] = '0;
    endtask

    // Hyperspherical angles of wv into row j; queue the operand pairs the DUT must issue.
    task automatic model_run(input int j);
        int            acc;
        logic [AW-1:0] th;
        logic [DW-1:0] mg;
        acc = wv[0];
        exp_pulses = 0;
        for (int i = 1; i < N; i++) begin
            if (acc == 0 && wv[i] == 0) begin
                th = '0;
            end else begin
                op_q.push_back({16'(acc), 16'(wv[i])});
                exp_pulses++;
                cordic_fn(acc, wv[i], th, mg);
                acc = int'($signed(mg));
            end
            exp_buf[j][i-1] = th;
        end
        exp_norm = acc;
    endtask

    task automatic drive_w();
        for (int i = 0; i < N; i++)
            w_in_flat[i*DW +: DW] = 16'(wv[i]);
    endtask

    task automatic run_vec(input int j, input bit with_clear, input bit inject, output int lat);
        @(negedge clk);
        if (with_clear) model_clear();
        model_run(j);
        drive_w();
        j_in   = 3'(j);
        start  = 1'b1;
        clear  = with_clear;
        en_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        lat   = 1;
        while (!done && lat < 1000) begin
            @(negedge clk);
            lat++;
            if (inject && lat == 10) begin
                start     = 1'b1;
                j_in      = 3'd0;
                w_in_flat = ~w_in_flat;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        @(negedge clk);
    endtask

    // Behavioural CORDIC: fixed latency, one result per issue.
    initial begin
        forever begin
            @(negedge clk);
            cordic_vec_opvld = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    cordic_vec_opvld = 1'b1;
                    vec_angle_out    = c_ang;
                    cordic_vec_xout  = c_mag;
                end
            end
            if (cordic_vec_en) begin
                cordic_fn(int'($signed(cordic_vec_xin)), int'($signed(cordic_vec_yin)), c_ang, c_mag);
                pend = LAT;
            end
        end
    end

    // Compare process: issue operands, done-cycle results and idle-state buffer every cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk("calc_en_tracks_en", cordic_vec_angle_calc_en, cordic_vec_en);
            if (cordic_vec_en) begin
                en_cnt++;
                if (op_q.size() == 0) begin
                    chk("unexpected_issue", 1, 0);
                end else begin
                    exp_op = op_q.pop_front();
                    chk("xin", cordic_vec_xin, exp_op[31:16]);
                    chk("yin", cordic_vec_yin, exp_op[15:0]);
                end
            end
            if (done) begin
                done_cnt++;
                chk_flat("buf_at_done", thetas_out_flat, exp_flat());
                chk("norm_at_done", int'($signed(norm_out)), exp_norm);
                chk("busy_at_done", busy, 1);
                chk("pulses_at_done", en_cnt, exp_pulses);
            end else if (!busy && rst_n) begin
                chk_flat("buf_idle", thetas_out_flat, exp_flat());
                chk("norm_idle", int'($signed(norm_out)), exp_norm);
            end
            if (err) err_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cyc;
        model_clear();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_en", cordic_vec_en, 0);
        chk("rst_norm", norm_out, 0);
        chk("rst_buf_zero", (thetas_out_flat == '0), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Pure x axis: all angles zero
        wv = '{100, 0, 0, 0, 0, 0, 0};
        run_vec(0, 1'b0, 1'b0, lat);
        chk("lat_run0", lat, 6 * (LAT + 3) + 2);
        chk("pulses_run0", en_cnt, 6);
        chk("norm_run0", norm_out, 100);
        chk("row0_zero", (thetas_out_flat[0 +: 96] == '0), 1);
        chk("done_cnt_run0", done_cnt, 1);

        // Pure y axis: first angle +pi/2
        wv = '{0, 100, 0, 0, 0, 0, 0};
        run_vec(1, 1'b0, 1'b0, lat);
        chk_near("theta10", int'(thetas_out_flat[96 +: 16]), 16384, 2);
        chk("row1_rest_zero", (thetas_out_flat[112 +: 80] == '0), 1);
        chk_near("norm_run1", int'(norm_out), 100, 1);

        // Diagonal: pi/4 and sqrt(2) magnitude; earlier rows untouched
        wv = '{100, 100, 0, 0, 0, 0, 0};
        run_vec(2, 1'b0, 1'b0, lat);
        chk_near("theta20", int'(thetas_out_flat[192 +: 16]), 8192, 2);
        chk_near("norm_run2", int'(norm_out), 141, 1);
        chk("row0_kept", (thetas_out_flat[0 +: 96] == '0), 1);
        chk_near("theta10_kept", int'(thetas_out_flat[96 +: 16]), 16384, 2);

        // All-zero vector: CORDIC never used
        wv = '{0, 0, 0, 0, 0, 0, 0};
        run_vec(3, 1'b0, 1'b0, lat);
        chk("lat_zero", lat, 2 + 6 * 2);
        chk("pulses_zero", en_cnt, 0);
        chk("norm_zero", norm_out, 0);
        chk("row3_zero", (thetas_out_flat[288 +: 96] == '0), 1);

        // Out-of-range row
        @(negedge clk);
        j_in  = 3'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(negedge clk);
        chk("err_one_cycle", err, 0);
        chk("err_cnt", err_cnt, 1);

        // Mixed-sign vector with a start injected mid-run
        wv = '{3000, -2000, 1500, 500, -700, 0, 1200};
        run_vec(4, 1'b0, 1'b1, lat);
        chk("lat_run4", lat, 6 * (LAT + 3) + 2);
        chk("done_cnt_run4", done_cnt, 5);
        chk("err_cnt_run4", err_cnt, 1);

        // Reset during WAIT of the third step
        wv = '{-500, 300, -200, 100, 50, -25, 10};
        @(negedge clk);
        model_run(5);
        drive_w();
        j_in   = 3'd5;
        start  = 1'b1;
        en_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (en_cnt < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_step3", (en_cnt >= 3), 1);
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        op_q.delete();
        exp_norm = 0;
        #1;
        chk("arst_en", cordic_vec_en, 0);
        chk("arst_calc_en", cordic_vec_angle_calc_en, 0);
        chk("arst_xin", cordic_vec_xin, 0);
        chk("arst_yin", cordic_vec_yin, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_norm", norm_out, 0);
        chk("arst_buf", (thetas_out_flat == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("late_opvld_busy", busy, 0);
        chk("late_opvld_done_cnt", done_cnt, 5);
        chk("late_opvld_no_issue", en_cnt, 3);

        // Write a row then clear it
        wv = '{100, 100, 0, 0, 0, 0, 0};
        run_vec(0, 1'b0, 1'b0, lat);
        chk_near("theta00", int'(thetas_out_flat[0 +: 16]), 8192, 2);
        @(negedge clk);
        clear = 1'b1;
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        chk("clear_buf", (thetas_out_flat == '0), 1);

        // Clear and start together: clear first, then the new row is written
        wv = '{100, 100, 0, 0, 0, 0, 0};
        run_vec(2, 1'b0, 1'b0, lat);
        wv = '{0, 100, 0, 0, 0, 0, 0};
        run_vec(1, 1'b1, 1'b0, lat);
        chk("row2_cleared", (thetas_out_flat[192 +: 96] == '0), 1);
        chk_near("theta10_after_clear", int'(thetas_out_flat[96 +: 16]), 16384, 2);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/theta_extract.md
Name: theta_extract

Overview:
- Upstream neighbour of gso_top in the Simplex-FastICA datapath.
- Takes one converged N_DIM weight vector w_j and converts it to hyperspherical rotation angles. It drives an external CORDIC_doubly_pipe_top in vectoring mode, one coordinate pair at a time.
- Writes the N_DIM-1 angles into row j of a K_VECTORS x K_VECTORS theta buffer.
- The buffer's flat output connects directly to gso_top thetas_in_flat. The final CORDIC magnitude is exported as the vector norm.

Parameters:
- DATA_WIDTH, 16, signed vector element width.
- ANGLE_WIDTH, 16, signed angle width; LSB = pi/2^(ANGLE_WIDTH-1), so 16'h4000 = +pi/2.
- N_DIM, 7, vector dimension.
- K_VECTORS, N_DIM-1, number of angle rows and angles per row.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- clear  in  1  synchronous zeroing of the whole theta buffer; honoured only in IDLE
- j_in  in  3  destination row
- w_in_flat  in  DATA_WIDTH*N_DIM  element i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]; captured on start
- cordic_vec_en  out  1  one-cycle issue pulse to CORDIC vectoring
- cordic_vec_xin  out  DATA_WIDTH  registered x operand
- cordic_vec_yin  out  DATA_WIDTH  registered y operand
- cordic_vec_angle_calc_en  out  1  high in the same cycle as cordic_vec_en
- cordic_vec_opvld  in  1  CORDIC result valid
- cordic_vec_xout  in  DATA_WIDTH  gain-compensated magnitude
- vec_angle_out  in  ANGLE_WIDTH  full-range angle in (-pi,pi]
- thetas_out_flat  out  ANGLE_WIDTH*K_VECTORS*K_VECTORS  entry (j,i) at [(j*K_VECTORS+i+1)*ANGLE_WIDTH-1 -: ANGLE_WIDTH]
- norm_out  out  DATA_WIDTH  final magnitude of the last run
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse when the row is written
- err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (asynchronous, rst_n=0) puts every output and state register at zero and the FSM in IDLE. This includes cordic_vec_en, cordic_vec_xin, cordic_vec_yin, cordic_vec_angle_calc_en, busy, done, err, norm_out, the theta buffer, the index counter, the accumulator and the captured vector.
- Reset mid-operation aborts the run; a CORDIC opvld arriving afterwards is ignored because the FSM is in IDLE.
- Algorithm: acc = w[0]; for i = 1 .. N_DIM-1: (acc, theta[j][i-1]) = vectoring(x=acc, y=w[i]). After the last step, norm_out = acc.
- FSM states: IDLE, ISSUE, WAIT, STORE, FIN.
- IDLE with start=1 and j_in < K_VECTORS: capture w_in_flat and j_in, set acc = w[0] and i = 1, go to ISSUE.
- IDLE with start=1 and j_in >= K_VECTORS: pulse err the next cycle, no buffer change, stay in IDLE.
- ISSUE: if acc == 0 and w[i] == 0 (zero pair), skip the CORDIC entirely; theta = 0, acc stays 0, go to STORE.
- ISSUE otherwise: drive xin = acc and yin = w[i]; pulse cordic_vec_en and cordic_vec_angle_calc_en for exactly one cycle; go to WAIT.
- WAIT: hold until cordic_vec_opvld=1, then latch vec_angle_out and cordic_vec_xout and go to STORE. There is no timeout, and only one operation is outstanding at a time.
- STORE: write theta into row j, entry i-1, and load acc. If i == N_DIM-1, go to FIN; otherwise increment i and go to ISSUE.
- FIN: update norm_out, pulse done, return to IDLE.
- Latency is N_DIM-1 x (CORDIC latency + 3) + 2 cycles, measured from the start cycle to the done cycle.
- start while busy is ignored, with no err.
- clear and start asserted together in IDLE: clear takes effect first, then the start is accepted in the same cycle.
- Rows other than j_in are never modified by a run. thetas_out_flat is registered and changes only in STORE.
- The accumulator stays DATA_WIDTH wide. Magnitude overflow (norm > 2^(DATA_WIDTH-1)-1) is the upstream normaliser's responsibility and is not checked here.

Decomposition:
- Shared package gso_pkg: ANGLE_HALF_PI (16'h4000), the angle LSB convention, the flat-index helper (j*K_VECTORS+i), and the FSM state encoding.
- The CORDIC stays external, mirroring how gso_top is integrated.
- One natural sub-module, theta_row_buf: a K_VECTORS x K_VECTORS register array with row/column write, clear, and flat output.

Test Plan:
- w = (100,0,0,0,0,0,0), j = 0 -> row 0 all 16'h0000, norm_out = 100, 6 cordic_vec_en pulses, done once.
- w = (0,100,0,0,0,0,0), j = 1 -> theta[1][0] = 16'h4000 ±2 LSB, all others 0, norm_out = 100 ±1.
- w = (100,100,0,0,0,0,0), j = 2 -> theta[2][0] = 16'h2000 ±2 LSB, norm_out = 141 ±1; rows 0 and 1 unchanged from the previous runs.
- w all zero, j = 3 -> zero cordic_vec_en pulses, row 3 all 0, norm_out = 0, done after 2+6x2 cycles.
- j_in = 6 -> err pulse, busy stays 0, buffer unchanged; a start pulse mid-run is ignored.
- rst_n low during WAIT of step 3 -> all outputs 0 immediately; a late opvld has no effect; clear zeroes a previously written row.
